// File: rtl/uart_host_master_pkg.sv
// Shared definitions for the host-side UART command initiator:
// opcodes, frame field layout, response codes and FSM states.
package host_frame_pkg;

  localparam logic [15:0] OP_MEM_WR  = 16'd0;
  localparam logic [15:0] OP_MEM_RD  = 16'd1;
  localparam logic [15:0] OP_GPIO_WR = 16'd2;
  localparam logic [15:0] OP_GPIO_RD = 16'd3;

  // Top bit of each field in the 64-bit frame
  localparam int OPC_HI = 63;
  localparam int ADR_HI = 47;
  localparam int DAT_HI = 31;

  typedef enum logic [1:0] {
    ERR_OK         = 2'd0,
    ERR_TIMEOUT    = 2'd1,
    ERR_MISMATCH   = 2'd2,
    ERR_BAD_OPCODE = 2'd3
  } err_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_TX,
    ST_WAIT_RSP,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic [15:0] opcode;
    logic [15:0] addr;
    logic [31:0] data;
  } frame_t;

  function automatic logic is_read(input logic [15:0] opcode);
    return (opcode == OP_MEM_RD) || (opcode == OP_GPIO_RD);
  endfunction

  function automatic logic is_known(input logic [15:0] opcode);
    return (opcode == OP_MEM_WR) || (opcode == OP_MEM_RD) ||
           (opcode == OP_GPIO_WR) || (opcode == OP_GPIO_RD);
  endfunction

endpackage

// File: rtl/uart_host_master_if.sv
// Command, frame TX/RX and response signals of the host UART initiator.
// master = initiator view, slave = host logic / link endpoint view.
interface uart_host_master_if;
  logic        iCMD_VALID;
  logic        oCMD_READY;
  logic [15:0] iCMD_OPCODE;
  logic [15:0] iCMD_ADDR;
  logic [31:0] iCMD_DATA;
  logic        oTX_REQ;
  logic [63:0] oTX_FRAME;
  logic        iTX_DONE;
  logic        iRX_DONE;
  logic [63:0] iRX_FRAME;
  logic        oRSP_VALID;
  logic [31:0] oRSP_DATA;
  logic [1:0]  oRSP_ERR;
  logic        oBUSY;

  modport master (
    input  iCMD_VALID, iCMD_OPCODE, iCMD_ADDR, iCMD_DATA,
    input  iTX_DONE, iRX_DONE, iRX_FRAME,
    output oCMD_READY, oTX_REQ, oTX_FRAME,
    output oRSP_VALID, oRSP_DATA, oRSP_ERR, oBUSY
  );

  modport slave (
    output iCMD_VALID, iCMD_OPCODE, iCMD_ADDR, iCMD_DATA,
    output iTX_DONE, iRX_DONE, iRX_FRAME,
    input  oCMD_READY, oTX_REQ, oTX_FRAME,
    input  oRSP_VALID, oRSP_DATA, oRSP_ERR, oBUSY
  );
endinterface

// File: rtl/uart_host_master_timer.sv
// Response timeout counter: clears on clr, counts on en, and parks at the
// terminal value so it can never wrap back into the waiting window.
module host_timeout_timer #(
  parameter int TOW    = 23,
  parameter int TC_VAL = 4999999
) (
  input  logic iCLOCK,
  input  logic iRESET,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [TOW-1:0] cnt;

  assign tc = (cnt == TOW'(TC_VAL));

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET)          cnt <= '0;
    else if (clr)        cnt <= '0;
    else if (en && !tc)  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_host_master.sv
// Host UART initiator: packs one command into a frame, drives the transmitter
// and, for reads, validates the kernel's reply. `define HOST_RETRY_EN to resend on timeout.
module uart_host_master
  import host_frame_pkg::*;
#(
  parameter int TIMEOUT_CYC = 5000000,
  parameter int TOW         = 23,
  parameter int MAX_RETRY   = 2
) (
  input  logic                  iCLOCK,
  input  logic                  iRESET,
  uart_host_master_if.master    bus
);

`ifdef HOST_RETRY_EN
  localparam bit RETRY_ON = 1'b1;
`else
  localparam bit RETRY_ON = 1'b0;
`endif
  localparam int RW = $clog2(MAX_RETRY + 2);

  state_e         state, state_n;
  frame_t         frame;
  logic [31:0]    rsp_data, rsp_data_n;
  err_e           rsp_err, rsp_err_n;
  logic           rsp_ld, retry_inc;
  logic [RW-1:0]  retry_cnt;
  logic           accept, tmr_en, tmr_tc, rx_match, can_retry;
  logic [15:0]    rx_opc, rx_adr;
  logic [31:0]    rx_dat;

  assign accept    = bus.iCMD_VALID && (state == ST_IDLE);
  assign rx_opc    = bus.iRX_FRAME[OPC_HI -: 16];
  assign rx_adr    = bus.iRX_FRAME[ADR_HI -: 16];
  assign rx_dat    = bus.iRX_FRAME[DAT_HI:0];
  // GPIO reads carry no meaningful address in the reply
  assign rx_match  = (rx_opc == frame.opcode) &&
                     ((frame.opcode == OP_GPIO_RD) || (rx_adr == frame.addr));
  assign can_retry = RETRY_ON && (retry_cnt < RW'(MAX_RETRY));

  // Timer starts on the iTX_DONE cycle so a timeout lands TIMEOUT_CYC cycles after it
  assign tmr_en = (state == ST_WAIT_RSP) ||
                  ((state == ST_WAIT_TX) && bus.iTX_DONE && is_read(frame.opcode));

  host_timeout_timer #(
    .TOW    (TOW),
    .TC_VAL (TIMEOUT_CYC - 1)
  ) u_timer (
    .iCLOCK (iCLOCK),
    .iRESET (iRESET),
    .clr    (!tmr_en),
    .en     (tmr_en),
    .tc     (tmr_tc)
  );

  always_comb begin
    state_n    = state;
    rsp_ld     = 1'b0;
    rsp_data_n = '0;
    rsp_err_n  = ERR_OK;
    retry_inc  = 1'b0;
    case (state)
      ST_IDLE: if (accept) state_n = ST_SEND;
      ST_SEND: begin
        if (!is_known(frame.opcode)) begin
          state_n   = ST_RESP;
          rsp_ld    = 1'b1;
          rsp_err_n = ERR_BAD_OPCODE;
        end else begin
          state_n = ST_WAIT_TX;
        end
      end
      ST_WAIT_TX: begin
        if (bus.iTX_DONE) begin
          if (is_read(frame.opcode)) begin
            state_n = ST_WAIT_RSP;
          end else begin
            state_n = ST_RESP;
            rsp_ld  = 1'b1;
          end
        end
      end
      ST_WAIT_RSP: begin
        // A frame arriving on the timeout cycle still completes the read
        if (bus.iRX_DONE) begin
          state_n = ST_RESP;
          rsp_ld  = 1'b1;
          if (rx_match) rsp_data_n = rx_dat;
          else          rsp_err_n  = ERR_MISMATCH;
        end else if (tmr_tc) begin
          if (can_retry) begin
            state_n   = ST_SEND;
            retry_inc = 1'b1;
          end else begin
            state_n   = ST_RESP;
            rsp_ld    = 1'b1;
            rsp_err_n = ERR_TIMEOUT;
          end
        end
      end
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      frame     <= '0;
      rsp_data  <= '0;
      rsp_err   <= ERR_OK;
      retry_cnt <= '0;
    end else begin
      if (accept) begin
        frame     <= {bus.iCMD_OPCODE, bus.iCMD_ADDR, bus.iCMD_DATA};
        retry_cnt <= '0;
      end else if (retry_inc) begin
        retry_cnt <= retry_cnt + 1'b1;
      end
      if (rsp_ld) begin
        rsp_data <= rsp_data_n;
        rsp_err  <= rsp_err_n;
      end
    end
  end

  assign bus.oCMD_READY = (state == ST_IDLE);
  assign bus.oBUSY      = (state != ST_IDLE);
  assign bus.oTX_REQ    = (state == ST_SEND) && is_known(frame.opcode);
  assign bus.oTX_FRAME  = frame;
  assign bus.oRSP_VALID = (state == ST_RESP);
  assign bus.oRSP_DATA  = rsp_data;
  assign bus.oRSP_ERR   = rsp_err;

endmodule

// File: tb/tb_uart_host_master.sv
// Randomized bench for uart_host_master: a transaction-level model predicts
// when each TX request and response must appear and what they carry.
module tb_uart_host_master;

  localparam int T = 100;
`ifdef HOST_RETRY_EN
  localparam int RETRIES = 2;
`else
  localparam int RETRIES = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_host_master_if bus();

  uart_host_master #(.TIMEOUT_CYC(T), .TOW(23), .MAX_RETRY(2)) dut (
    .iCLOCK (clk),
    .iRESET (rst),
    .bus    (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int cyc; logic [1:0] err; logic [31:0] data;} rsp_t;

  int          total = 0, bad = 0;
  int          txq[$];
  rsp_t        rq[$];
  logic [63:0] cur_frame = '0;
  bit          tx_win = 0, txn_open = 0;
  int          n_tx = 0, last_rsp_cyc = 0, last_td = 0, last_acc = 0, n0;
  logic [63:0] last_tx_frame = '0;
  logic [1:0]  last_rsp_err = '0;
  logic [31:0] last_rsp_data = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Compare process: every cycle out of reset
  always @(negedge clk) begin
    bit et, er;
    if (!rst) begin
      et = (txq.size() > 0) && (txq[0] == cyc);
      chk("tx_req", bus.oTX_REQ, et);
      if (bus.oTX_REQ) begin n_tx++; last_tx_frame = bus.oTX_FRAME; end
      if (et) void'(txq.pop_front());
      if (tx_win) chk("tx_frame", bus.oTX_FRAME, cur_frame);
      chk("cmd_ready", bus.oCMD_READY, !txn_open);
      chk("busy", bus.oBUSY, txn_open);
      er = (rq.size() > 0) && (rq[0].cyc == cyc);
      chk("rsp_valid", bus.oRSP_VALID, er);
      if (er) begin
        chk("rsp_err", bus.oRSP_ERR, rq[0].err);
        chk("rsp_data", bus.oRSP_DATA, rq[0].data);
        last_rsp_err  = bus.oRSP_ERR;
        last_rsp_data = bus.oRSP_DATA;
        last_rsp_cyc  = cyc;
        void'(rq.pop_front());
        txn_open = 0;
        tx_win   = 0;
      end
    end
  end

  task automatic idle(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_ready", bus.oCMD_READY, 1);
    chk("rst_busy", bus.oBUSY, 0);
    chk("rst_tx_req", bus.oTX_REQ, 0);
    chk("rst_tx_frame", bus.oTX_FRAME, 0);
    chk("rst_rsp_valid", bus.oRSP_VALID, 0);
    chk("rst_rsp_data", bus.oRSP_DATA, 0);
    chk("rst_rsp_err", bus.oRSP_ERR, 0);
  endtask

  // mode 0: correct reply, 1: reply with frame rxf, 2: no reply
  task automatic run_cmd(input logic [15:0] op, input logic [15:0] ad, input logic [31:0] dt,
                         input int mode, input logic [63:0] rxf, input int rdly);
    int s, td, rc, att;
    bit done;
    logic [1:0]  e;
    logic [31:0] dd;
    logic [63:0] f;
    td = 0; rc = 0; att = 0; done = 0; e = 0; dd = 0;
    bus.iCMD_VALID = 1; bus.iCMD_OPCODE = op; bus.iCMD_ADDR = ad; bus.iCMD_DATA = dt;
    last_acc = cyc;
    @(posedge clk); #1;
    bus.iCMD_VALID = 0; bus.iCMD_OPCODE = 16'($urandom); bus.iCMD_DATA = $urandom;
    cur_frame = {op, ad, dt}; tx_win = 1; txn_open = 1;
    if (op > 3) begin
      rc = last_acc + 2; e = 2'd3;
    end else begin
      s = last_acc + 1;
      while (!done) begin
        txq.push_back(s);
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
        bus.iTX_DONE = 1; td = cyc;
        @(posedge clk); #1;
        bus.iTX_DONE = 0;
        if (op == 0 || op == 2) begin
          rc = td + 1; done = 1;
        end else if (mode == 2) begin
          if (att < RETRIES) begin
            att++; s = td + T;
            while (cyc < s) begin @(posedge clk); #1; end
          end else begin
            rc = td + T; e = 2'd1; done = 1;
          end
        end else begin
          f = (mode == 0) ? {op, (op == 3) ? 16'($urandom) : ad, 32'($urandom)} : rxf;
          idle(rdly - 1);
          bus.iRX_DONE = 1; bus.iRX_FRAME = f;
          @(posedge clk); #1;
          bus.iRX_DONE = 0; bus.iRX_FRAME = {$urandom, $urandom};
          rc = td + rdly + 1;
          if (f[63:48] == op && (op == 3 || f[47:32] == ad)) dd = f[31:0];
          else e = 2'd2;
          done = 1;
        end
      end
    end
    rq.push_back('{rc, e, dd});
    last_td = td;
    while (cyc <= rc) begin @(posedge clk); #1; end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.iCMD_VALID = 0; bus.iCMD_OPCODE = 0; bus.iCMD_ADDR = 0; bus.iCMD_DATA = 0;
    bus.iTX_DONE = 0; bus.iRX_DONE = 0; bus.iRX_FRAME = 0;
    #2;
    chk_reset_vals();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    idle(2);

    n0 = n_tx;
    run_cmd(16'd0, 16'd1000, 32'hDEADBEEF, 0, 64'd0, 1);
    chk("wr_frame", last_tx_frame, 64'h0000_03E8_DEADBEEF);
    chk("wr_ntx", n_tx - n0, 1);
    chk("wr_lat", last_rsp_cyc - last_td, 1);
    chk("wr_err", last_rsp_err, 0);
    chk("wr_data", last_rsp_data, 0);

    run_cmd(16'd1, 16'd3048, 32'd0, 1, 64'h0001_0BE8_12345678, 3);
    chk("rd_data", last_rsp_data, 32'h12345678);
    chk("rd_err", last_rsp_err, 0);
    chk("rd_lat", last_rsp_cyc - last_td, 4);

    run_cmd(16'd3, 16'h0055, 32'd0, 1, 64'h0003_0000_00000001, 2);
    chk("gpio_data", last_rsp_data, 1);
    chk("gpio_err", last_rsp_err, 0);
    run_cmd(16'd3, 16'h0055, 32'd0, 1, 64'h0001_0000_00000001, 2);
    chk("gpio_mm_err", last_rsp_err, 2);
    chk("gpio_mm_data", last_rsp_data, 0);

    n0 = n_tx;
    run_cmd(16'd1, 16'h1234, 32'd0, 2, 64'd0, 1);
    chk("to_lat", last_rsp_cyc - last_td, 100);
    chk("to_err", last_rsp_err, 1);
    chk("to_ntx", n_tx - n0, RETRIES + 1);

    n0 = n_tx;
    run_cmd(16'd7, 16'h0001, 32'h1, 0, 64'd0, 1);
    chk("bad_lat", last_rsp_cyc - last_acc, 2);
    chk("bad_err", last_rsp_err, 3);
    chk("bad_ntx", n_tx - n0, 0);

    // Stray link events while idle must not disturb anything
    bus.iRX_DONE = 1; bus.iRX_FRAME = 64'h0001_0BE8_0000_0001; bus.iTX_DONE = 1;
    @(posedge clk); #1;
    bus.iRX_DONE = 0; bus.iTX_DONE = 0;
    idle(3);
    chk("stray_ready", bus.oCMD_READY, 1);
    chk("stray_busy", bus.oBUSY, 0);

    // Reply on the very cycle the timer expires
    run_cmd(16'd1, 16'h0BE8, 32'd0, 1, 64'h0001_0BE8_CAFEF00D, T - 1);
    chk("tie_data", last_rsp_data, 32'hCAFEF00D);
    chk("tie_err", last_rsp_err, 0);

    for (int i = 0; i < 40; i++) begin
      logic [15:0] op, ad;
      logic [63:0] rxf;
      int pick, m, mode;
      pick = $urandom_range(0, 19);
      op   = (pick < 18) ? 16'(pick % 4) : 16'($urandom_range(4, 65535));
      ad   = 16'($urandom);
      m    = $urandom_range(0, 9);
      mode = (m < 6) ? 0 : ((m < 9) ? 1 : 2);
      case ($urandom_range(0, 2))
        0:       rxf = {op ^ (16'h1 << $urandom_range(0, 15)), ad, 32'($urandom)};
        1:       rxf = {op, 16'($urandom), 32'($urandom)};
        default: rxf = {op, ad, 32'($urandom)};
      endcase
      run_cmd(op, ad, $urandom, mode, rxf, $urandom_range(1, 30));
      idle($urandom_range(0, 3));
    end

    // Reset in the middle of WAIT_RSP
    bus.iCMD_VALID = 1; bus.iCMD_OPCODE = 16'd1; bus.iCMD_ADDR = 16'd5; bus.iCMD_DATA = 0;
    last_acc = cyc;
    @(posedge clk); #1;
    bus.iCMD_VALID = 0;
    cur_frame = {16'd1, 16'd5, 32'd0}; tx_win = 1; txn_open = 1;
    txq.push_back(last_acc + 1);
    idle(2);
    bus.iTX_DONE = 1;
    @(posedge clk); #1;
    bus.iTX_DONE = 0;
    idle(5);
    #2 rst = 1;
    #1;
    chk_reset_vals();
    txn_open = 0; tx_win = 0; txq.delete(); rq.delete();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("post_rst_ready", bus.oCMD_READY, 1);
    idle(T + 20);

    chk("txq_empty", txq.size(), 0);
    chk("rq_empty", rq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
